// File: rtl/tpu_writeback.sv
// TPU result writeback: buffers one tile of result rows, optionally
// applies ReLU per lane, then drains the rows to memory in order.
module tpu_writeback #(
  parameter int ROWS   = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              row_valid,
  input  logic [127:0]      row_data,
  input  logic              row_last,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              cfg_relu,
  input  logic              err_clr,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_data,
  output logic              busy,
  output logic              wb_done,
  output logic              err_ovf
);

  localparam int CW = $clog2(ROWS + 1);
  localparam int IW = $clog2(ROWS);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              relu_q, relu_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic [127:0]      buf_q [ROWS];
  logic              store;
  logic [IW-1:0]     store_idx;
  logic [127:0]      store_data;

  // Lanes with the sign bit set are zeroed when ReLU is enabled.
  function automatic logic [127:0] relu_row(
    input logic [127:0] r,
    input logic         en
  );
    logic [127:0] o;
    o = r;
    for (int i = 0; i < 16; i++) begin
      if (en && r[8*i+7]) o[8*i +: 8] = 8'h00;
    end
    return o;
  endfunction

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    base_d     = base_q;
    relu_d     = relu_q;
    done_d     = 1'b0;
    store      = 1'b0;
    store_idx  = wr_cnt_q[IW-1:0];
    store_data = relu_row(row_data, relu_q);
    ovf_d      = err_clr ? 1'b0 : ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (row_valid) begin
          store      = 1'b1;
          store_idx  = '0;
          store_data = relu_row(row_data, cfg_relu);
          base_d     = cfg_base;
          relu_d     = cfg_relu;
          wr_cnt_d   = ONE;
          state_d    = row_last ? S_DRAIN : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (row_valid) begin
          store    = 1'b1;
          wr_cnt_d = wr_cnt_q + ONE;
          if (row_last || wr_cnt_q == LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Rows arriving while draining cannot be buffered.
        if (row_valid) ovf_d = 1'b1;
        if (mem_ready) begin
          if (rd_ptr_q == wr_cnt_q - ONE) begin
            state_d  = S_IDLE;
            rd_ptr_d = '0;
            wr_cnt_d = '0;
            done_d   = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      base_q   <= '0;
      relu_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      base_q   <= base_d;
      relu_q   <= relu_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) buf_q[store_idx] <= store_data;
  end

  always_comb begin
    mem_valid = (state_q == S_DRAIN);
    mem_addr  = '0;
    mem_data  = '0;
    if (mem_valid) begin
      mem_addr = base_q + ADDR_W'(rd_ptr_q);
      mem_data = buf_q[rd_ptr_q[IW-1:0]];
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign wb_done = done_q;
  assign err_ovf = ovf_q;

endmodule

// File: tb/tb_tpu_writeback.sv
// Directed self-checking bench for tpu_writeback.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_tpu_writeback;

  logic         clk = 1'b0;
  logic         rst;
  logic         row_valid;
  logic [127:0] row_data;
  logic         row_last;
  logic [9:0]   cfg_base;
  logic         cfg_relu;
  logic         err_clr;
  logic         mem_valid;
  logic         mem_ready;
  logic [9:0]   mem_addr;
  logic [127:0] mem_data;
  logic         busy;
  logic         wb_done;
  logic         err_ovf;

  int n_chk = 0;
  int n_fail = 0;

  logic [127:0] d [4];

  always #5 clk = ~clk;

  tpu_writeback #(.ROWS(16), .ADDR_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_valid (row_valid),
    .row_data  (row_data),
    .row_last  (row_last),
    .cfg_base  (cfg_base),
    .cfg_relu  (cfg_relu),
    .err_clr   (err_clr),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .wb_done   (wb_done),
    .err_ovf   (err_ovf)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic row(input logic [127:0] dat, input logic last,
                     input logic [9:0] base, input logic relu);
    row_valid = 1'b1;
    row_data  = dat;
    row_last  = last;
    cfg_base  = base;
    cfg_relu  = relu;
    tick();
    row_valid = 1'b0;
    row_last  = 1'b0;
    row_data  = '0;
  endtask

  task automatic wr(input string tag, input logic [9:0] a,
                    input logic [127:0] dat);
    chk({tag, "_valid"}, 128'(mem_valid), 128'(1'b1));
    chk({tag, "_addr"}, 128'(mem_addr), 128'(a));
    chk({tag, "_data"}, mem_data, dat);
  endtask

  task automatic done_chk(input string tag);
    chk({tag, "_done"}, 128'(wb_done), 128'(1'b1));
    chk({tag, "_vld0"}, 128'(mem_valid), 128'(1'b0));
    chk({tag, "_busy0"}, 128'(busy), 128'(1'b0));
    tick();
    chk({tag, "_done0"}, 128'(wb_done), 128'(1'b0));
  endtask

  initial begin
    rst = 1'b0;
    row_valid = 1'b0;
    row_data = '0;
    row_last = 1'b0;
    cfg_base = '0;
    cfg_relu = 1'b0;
    err_clr = 1'b0;
    mem_ready = 1'b1;
    d[0] = 128'h0011_2233_4455_6677_0011_2233_4455_6677;
    d[1] = 128'h1234_5678_1234_5678_1234_5678_1234_5678;
    d[2] = 128'h7f7f_0101_7f7f_0101_7f7f_0101_7f7f_0101;
    d[3] = 128'h0a0b_0c0d_0e0f_1011_1213_1415_1617_1819;

    // reset state
    tick();
    tick();
    chk("rst_valid", 128'(mem_valid), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_done", 128'(wb_done), 128'(1'b0));
    chk("rst_ovf", 128'(err_ovf), 128'(1'b0));
    chk("rst_addr", 128'(mem_addr), 128'(10'h0));
    chk("rst_data", mem_data, 128'h0);
    rst = 1'b1;
    tick();

    // full 16-row tile at 0x100
    for (int k = 0; k < 16; k++) begin
      if (k == 8) begin
        chk("full_collect_vld", 128'(mem_valid), 128'(1'b0));
        chk("full_collect_busy", 128'(busy), 128'(1'b1));
      end
      row({16{8'(k)}}, k == 15, 10'h100, 1'b0);
    end
    for (int k = 0; k < 16; k++) begin
      wr("full", 10'(10'h100 + k), {16{8'(k)}});
      chk("full_nodone", 128'(wb_done), 128'(1'b0));
      tick();
    end
    done_chk("full");

    // ReLU on, single-row tile
    row({8{16'h8505}}, 1'b1, 10'h010, 1'b1);
    wr("relu1", 10'h010, {8{16'h0005}});
    tick();
    done_chk("relu1");

    // ReLU latched with first row, cfg_relu dropped on row 1
    row({8{16'h8505}}, 1'b0, 10'h018, 1'b1);
    row({8{16'h0585}}, 1'b1, 10'h000, 1'b0);
    wr("relu2a", 10'h018, {8{16'h0005}});
    tick();
    wr("relu2b", 10'h019, {8{16'h0500}});
    tick();
    done_chk("relu2");

    // ReLU off: data unchanged
    row({8{16'h8505}}, 1'b1, 10'h011, 1'b0);
    wr("relu0", 10'h011, {8{16'h8505}});
    tick();
    done_chk("relu0");

    // short tile with backpressure
    row(d[0], 1'b0, 10'h020, 1'b0);
    row(d[1], 1'b0, 10'h020, 1'b0);
    row(d[2], 1'b1, 10'h020, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      wr("bp_pre", 10'(10'h020 + i), d[i]);
      tick();
      wr("bp_stall", 10'(10'h020 + i), d[i]);
      chk("bp_nodone", 128'(wb_done), 128'(1'b0));
      mem_ready = 1'b1;
      tick();
    end
    done_chk("bp");
    chk("bp_idle_vld", 128'(mem_valid), 128'(1'b0));

    // overflow during drain, then clear
    row(d[0], 1'b0, 10'h040, 1'b0);
    row(d[1], 1'b0, 10'h040, 1'b0);
    row(d[2], 1'b1, 10'h040, 1'b0);
    wr("ovf0", 10'h040, d[0]);
    chk("ovf_pre", 128'(err_ovf), 128'(1'b0));
    row(d[3], 1'b1, 10'h3AA, 1'b1);
    chk("ovf_set", 128'(err_ovf), 128'(1'b1));
    wr("ovf1", 10'h041, d[1]);
    tick();
    wr("ovf2", 10'h042, d[2]);
    tick();
    done_chk("ovf");
    chk("ovf_sticky", 128'(err_ovf), 128'(1'b1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", 128'(err_ovf), 128'(1'b0));

    // set and clear together: set wins
    row(d[3], 1'b1, 10'h050, 1'b0);
    wr("ovfsc", 10'h050, d[3]);
    err_clr = 1'b1;
    row(d[0], 1'b1, 10'h060, 1'b0);
    err_clr = 1'b0;
    chk("ovf_setwins", 128'(err_ovf), 128'(1'b1));
    done_chk("ovfsc");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr2", 128'(err_ovf), 128'(1'b0));

    // address wrap, then back-to-back tile in wb_done cycle
    for (int i = 0; i < 4; i++) row(d[i], i == 3, 10'h3FE, 1'b0);
    wr("wrap0", 10'h3FE, d[0]);
    tick();
    wr("wrap1", 10'h3FF, d[1]);
    tick();
    wr("wrap2", 10'h000, d[2]);
    tick();
    wr("wrap3", 10'h001, d[3]);
    tick();
    chk("wrap_done", 128'(wb_done), 128'(1'b1));
    chk("wrap_busy0", 128'(busy), 128'(1'b0));
    row({8{16'h1e2d}}, 1'b1, 10'h200, 1'b0);
    wr("b2b", 10'h200, {8{16'h1e2d}});
    tick();
    done_chk("b2b");

    // reset mid-drain after 5 writes
    for (int k = 0; k < 8; k++) row({16{8'(8'h30 + k)}}, k == 7, 10'h080, 1'b0);
    for (int k = 0; k < 5; k++) begin
      wr("mid", 10'(10'h080 + k), {16{8'(8'h30 + k)}});
      tick();
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_vld", 128'(mem_valid), 128'(1'b0));
    chk("mid_rst_busy", 128'(busy), 128'(1'b0));
    chk("mid_rst_addr", 128'(mem_addr), 128'(10'h0));
    chk("mid_rst_data", mem_data, 128'h0);
    chk("mid_rst_done", 128'(wb_done), 128'(1'b0));
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_vld", 128'(mem_valid), 128'(1'b0));
    tick();
    chk("post_rst_vld2", 128'(mem_valid), 128'(1'b0));
    chk("post_rst_busy", 128'(busy), 128'(1'b0));
    row(d[1], 1'b1, 10'h300, 1'b0);
    wr("post", 10'h300, d[1]);
    tick();
    done_chk("post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
